// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle for fetch_prefetch_unit: imem request/response, redirect inputs and decode handoff.
// Optional FETCH_MISALIGN_TRAP_EN adds the fetch_misalign pulse to the bundle.
interface fetch_prefetch_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 17
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [XLEN-1:0]   imem_rsp_data;

  logic              br_en;
  logic              jal_en;
  logic              jalr_en;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   redir_base_pc;
  logic [XLEN-1:0]   jalr_pc;

  logic              dec_valid;
  logic              dec_ready;
  logic [XLEN-1:0]   dec_instr;
  logic [XLEN-1:0]   dec_pc;
  logic [XLEN-1:0]   dec_pc4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic              fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  br_en, jal_en, jalr_en, imm, redir_base_pc, jalr_pc,
    output dec_valid, dec_instr, dec_pc, dec_pc4,
    input  dec_ready,
    output fetch_misalign
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output br_en, jal_en, jalr_en, imm, redir_base_pc, jalr_pc,
    input  dec_valid, dec_instr, dec_pc, dec_pc4,
    output dec_ready,
    input  fetch_misalign
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  br_en, jal_en, jalr_en, imm, redir_base_pc, jalr_pc,
    output dec_valid, dec_instr, dec_pc, dec_pc4,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output br_en, jal_en, jalr_en, imm, redir_base_pc, jalr_pc,
    input  dec_valid, dec_instr, dec_pc, dec_pc4,
    output dec_ready
  );
`endif
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: PC register, credit-limited imem requests, QDEPTH instruction queue,
// redirect flush with stale-response discard. Optional macro FETCH_MISALIGN_TRAP_EN.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ADDR_W   = 17,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                   clk,
  input logic                   rst_n,
  fetch_prefetch_unit_if.master bus
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StDrain = 1'b1;

  // Control state
  logic [XLEN-1:0] r_pc;
  logic [0:0]      r_state;
  logic            r_active;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;

  // Instruction queue
  logic [XLEN-1:0] r_q_instr [QDEPTH];
  logic [XLEN-1:0] r_q_pc    [QDEPTH];
  logic [PW-1:0]   r_q_wptr;
  logic [PW-1:0]   r_q_rptr;
  logic [CW-1:0]   r_q_count;

  // PC of each outstanding request, in issue order
  logic [XLEN-1:0] r_pf_pc [QDEPTH];
  logic [PW-1:0]   r_pf_wptr;
  logic [PW-1:0]   r_pf_rptr;

  logic            w_redir;
  logic [XLEN-1:0] w_target_raw;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_credit_sum;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp;
  logic            w_rsp_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_dec_valid;
  logic [CW-1:0]   w_out_d;
  logic [CW-1:0]   w_discard_d;
  logic [0:0]      w_state_d;

  assign w_redir      = bus.jalr_en | bus.jal_en | bus.br_en;
  assign w_target_raw = bus.jalr_en ? bus.jalr_pc : (bus.redir_base_pc + bus.imm);
  assign w_target     = {w_target_raw[XLEN-1:2], 2'b00};

  // Queue entries plus in-flight requests never exceed QDEPTH, so a response always has a slot.
  assign w_credit_sum = {1'b0, r_q_count} + {1'b0, r_outstanding};
  assign w_req_valid  = r_active && (r_state == StRun) && (w_credit_sum < (CW+1)'(QDEPTH));
  assign w_req_fire   = w_req_valid & bus.imem_req_ready;

  assign w_rsp       = bus.imem_rsp_valid & (r_outstanding != '0);
  assign w_rsp_drop  = w_rsp & (r_discard != '0);
  assign w_push      = w_rsp & ~w_rsp_drop & ~w_redir;
  assign w_dec_valid = (r_q_count != '0) & ~w_redir;
  assign w_pop       = w_dec_valid & bus.dec_ready;

  assign w_out_d = r_outstanding + CW'(w_req_fire) - CW'(w_rsp);

  always_comb begin
    w_discard_d = r_discard;
    w_state_d   = r_state;
    if (w_redir) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_discard_d = w_out_d;
      w_state_d   = (w_out_d != '0) ? StDrain : StRun;
    end else begin
      if (w_rsp_drop) begin
        w_discard_d = r_discard - CW'(1);
      end
      if ((r_state == StDrain) && (w_discard_d == '0)) begin
        w_state_d = StRun;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_state       <= StRun;
      r_active      <= 1'b0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_q_wptr      <= '0;
      r_q_rptr      <= '0;
      r_q_count     <= '0;
      r_pf_wptr     <= '0;
      r_pf_rptr     <= '0;
    end else begin
      r_active      <= 1'b1;
      r_state       <= w_state_d;
      r_outstanding <= w_out_d;
      r_discard     <= w_discard_d;

      if (w_redir) begin
        r_pc <= w_target;
      end else if (w_req_fire) begin
        r_pc <= r_pc + XLEN'(4);
      end

      if (w_req_fire) begin
        r_pf_wptr <= r_pf_wptr + PW'(1);
      end
      if (w_rsp) begin
        r_pf_rptr <= r_pf_rptr + PW'(1);
      end

      if (w_redir) begin
        r_q_wptr  <= '0;
        r_q_rptr  <= '0;
        r_q_count <= '0;
      end else begin
        if (w_push) begin
          r_q_wptr <= r_q_wptr + PW'(1);
        end
        if (w_pop) begin
          r_q_rptr <= r_q_rptr + PW'(1);
        end
        r_q_count <= r_q_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage needs no reset: outputs are gated by the valid flags.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pf_pc[r_pf_wptr] <= r_pc;
    end
    if (w_push) begin
      r_q_instr[r_q_wptr] <= bus.imem_rsp_data;
      r_q_pc[r_q_wptr]    <= r_pf_pc[r_pf_rptr];
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = w_req_valid ? r_pc[ADDR_W+1:2] : '0;
  assign bus.dec_valid      = w_dec_valid;
  assign bus.dec_instr      = w_dec_valid ? r_q_instr[r_q_rptr] : '0;
  assign bus.dec_pc         = w_dec_valid ? r_q_pc[r_q_rptr] : '0;
  assign bus.dec_pc4        = w_dec_valid ? (r_q_pc[r_q_rptr] + XLEN'(4)) : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_redir && (w_target_raw[1:0] != 2'b00);
    end
  end

  assign bus.fetch_misalign = r_misalign;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: an in-order variable-latency memory plus a
// program-order model (expected next request PC and next decoded PC, reset by redirects).
module tb_fetch_prefetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_prefetch_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  fetch_prefetch_unit #(
    .XLEN    (XLEN),
    .ADDR_W  (ADDR_W),
    .QDEPTH  (QDEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } mreq_t;

  mreq_t       mq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          fires   = 0;
  int          pops    = 0;
  logic [31:0] m_req_pc;
  logic [31:0] m_dec_pc;
  logic [31:0] last_pop_pc;
  logic [31:0] last_fire_addr;
  logic        exp_mis;

  logic        p_req_ready, p_dec_ready, p_br, p_jal, p_jalr;
  logic [31:0] p_imm, p_base, p_jalr_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic tick();
    logic        fire, redir, mis;
    logic [31:0] tgt;
    int          lat, due;
    @(negedge clk);
    bus.imem_req_ready = p_req_ready;
    bus.dec_ready      = p_dec_ready;
    bus.br_en          = p_br;
    bus.jal_en         = p_jal;
    bus.jalr_en        = p_jalr;
    bus.imm            = p_imm;
    bus.redir_base_pc  = p_base;
    bus.jalr_pc        = p_jalr_pc;
    p_br = 1'b0; p_jal = 1'b0; p_jalr = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misalign", 32'(bus.fetch_misalign), 32'(exp_mis));
`endif
    fire  = bus.imem_req_valid & bus.imem_req_ready;
    redir = bus.br_en | bus.jal_en | bus.jalr_en;
    if (fire) begin
      check("req_addr", 32'(bus.imem_req_addr), 32'(m_req_pc[ADDR_W+1:2]));
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: bus.imem_req_addr, due: due});
      last_fire_addr = 32'(bus.imem_req_addr);
      m_req_pc = m_req_pc + 32'd4;
      fires++;
    end
    if (bus.imem_rsp_valid) void'(mq.pop_front());
    if (redir) begin
      check("dec_valid_on_redirect", 32'(bus.dec_valid), 32'h0);
      tgt = bus.jalr_en ? bus.jalr_pc : (bus.redir_base_pc + bus.imm);
      mis = (tgt[1:0] != 2'b00);
      tgt[1:0] = 2'b00;
      m_req_pc = tgt;
      m_dec_pc = tgt;
    end else begin
      mis = 1'b0;
      if (bus.dec_valid && bus.dec_ready) begin
        check("dec_pc", bus.dec_pc, m_dec_pc);
        check("dec_pc4", bus.dec_pc4, m_dec_pc + 32'd4);
        check("dec_instr", bus.dec_instr, mem_word(m_dec_pc[ADDR_W+1:2]));
        last_pop_pc = bus.dec_pc;
        m_dec_pc = m_dec_pc + 32'd4;
        pops++;
      end
    end
    exp_mis = mis;
    cyc++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'h0);
    check({tag, "_req_addr"}, 32'(bus.imem_req_addr), 32'h0);
    check({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'h0);
    check({tag, "_dec_instr"}, bus.dec_instr, 32'h0);
    check({tag, "_dec_pc"}, bus.dec_pc, 32'h0);
    check({tag, "_dec_pc4"}, bus.dec_pc4, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check({tag, "_misalign"}, 32'(bus.fetch_misalign), 32'h0);
`endif
  endtask

  // Reset asserted mid-cycle; memory keeps responding while reset is low.
  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    bus.br_en = 1'b0; bus.jal_en = 1'b0; bus.jalr_en = 1'b0;
    #1;
    check_outputs_zero("rst");
    mq.delete();
    last_due = cyc + hold;
    repeat (hold) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    m_req_pc = RESET_PC;
    m_dec_pc = RESET_PC;
    exp_mis  = 1'b0;
  endtask

  task automatic run(input int n, input int rdy_pct, input int drdy_pct, input int redir_pm);
    int k;
    for (int i = 0; i < n; i++) begin
      p_req_ready = ($urandom_range(99) < rdy_pct);
      p_dec_ready = ($urandom_range(99) < drdy_pct);
      if ($urandom_range(999) < redir_pm) begin
        k = $urandom_range(3);
        p_br      = (k == 0) || (k == 3);
        p_jal     = (k == 1);
        p_jalr    = (k >= 2);
        p_base    = $urandom;
        p_imm     = $urandom;
        p_jalr_pc = $urandom;
      end
      tick();
    end
  endtask

  initial begin
    int f0, p0;
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.br_en = 1'b0; bus.jal_en = 1'b0; bus.jalr_en = 1'b0;
    bus.imm = '0; bus.redir_base_pc = '0; bus.jalr_pc = '0; bus.dec_ready = 1'b0;
    p_br = 1'b0; p_jal = 1'b0; p_jalr = 1'b0;
    p_imm = '0; p_base = '0; p_jalr_pc = '0;
    p_req_ready = 1'b1; p_dec_ready = 1'b1;
    exp_mis = 1'b0; last_pop_pc = '1; last_fire_addr = '1;

    // Straight-line fetch, 1-cycle memory
    do_reset(2);
    lat_min = 1; lat_max = 1;
    p0 = pops;
    run(10, 100, 100, 0);
    check("linear_progress", 32'(pops - p0 >= 4), 32'h1);

    // Decode stall fills exactly QDEPTH entries
    do_reset(2);
    f0 = fires;
    run(12, 100, 0, 0);
    check("stall_fires", 32'(fires - f0), QDEPTH);
    check("stall_dec_valid", 32'(bus.dec_valid), 32'h1);
    check("stall_no_req", 32'(bus.imem_req_valid), 32'h0);
    p0 = pops;
    run(10, 100, 100, 0);
    check("stall_drain", 32'(pops - p0 >= 4), 32'h1);

    // Taken branch with responses in flight
    do_reset(2);
    lat_min = 3; lat_max = 3;
    run(6, 100, 100, 0);
    p_br = 1'b1; p_base = 32'h20; p_imm = 32'hFFFF_FFF8;
    tick();
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) run(1, 100, 100, 0);
    check("br_target_pc", last_pop_pc, 32'h18);

    // jalr beats jal; misaligned target bits cleared
    p_jalr = 1'b1; p_jal = 1'b1; p_jalr_pc = 32'h103; p_base = 32'h1000; p_imm = 32'h40;
    tick();
    f0 = fires;
    for (int i = 0; i < 30 && fires == f0; i++) run(1, 100, 100, 0);
    check("jalr_addr", last_fire_addr, 32'h40);
    p0 = pops;
    for (int i = 0; i < 30 && pops == p0; i++) run(1, 100, 100, 0);
    check("jalr_pc", last_pop_pc, 32'h100);

    // PC wrap past 0xFFFF_FFFC
    p_jalr = 1'b1; p_jalr_pc = 32'hFFFF_FFF8;
    tick();
    p0 = pops;
    run(20, 100, 100, 0);
    check("wrap_progress", 32'(pops - p0 >= 3), 32'h1);

    // Toggling request ready, fixed 3-cycle latency
    p0 = pops;
    run(200, 50, 100, 0);
    check("toggle_progress", 32'(pops - p0 > 40), 32'h1);

    // Reset with three requests outstanding
    do_reset(2);
    lat_min = 3; lat_max = 3;
    run(3, 100, 100, 0);
    check("pre_rst_outstanding", 32'(mq.size()), 32'd3);
    do_reset(3);
    f0 = fires;
    for (int i = 0; i < 10 && fires == f0; i++) run(1, 100, 100, 0);
    check("post_rst_addr", last_fire_addr, 32'(RESET_PC >> 2));

    // Random mix: latency 1..4, back-pressure both sides, random redirects
    lat_min = 1; lat_max = 4;
    p0 = pops;
    run(3000, 70, 75, 30);
    check("rand_progress", 32'(pops - p0 > 300), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
